// File: rtl/delay_n_cfg.sv
// Run-time configurable I/Q delay line: emits each accepted sample alongside the one
// accepted D valid-samples earlier, with fill tracking so reset/flush garbage is never flagged valid.
module delay_n_cfg #(
  parameter  int W     = 16,
  parameter  int N_MAX = 256,
  localparam int AW    = $clog2(N_MAX)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                flush,
  input  logic [AW:0]         cfg_delay,
  input  logic signed [W-1:0] rx_re_in,
  input  logic signed [W-1:0] rx_img_in,
  output logic                out_valid,
  output logic                dN_valid,
  output logic signed [W-1:0] r_real,
  output logic signed [W-1:0] r_imag,
  output logic signed [W-1:0] r_dN_real,
  output logic signed [W-1:0] r_dN_imag,
  output logic [AW:0]         fill_cnt
);

  localparam logic [AW:0] DELAY_MAX = (AW+1)'(N_MAX);
  localparam logic [AW:0] DELAY_MIN = (AW+1)'(1);

  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]         delay_q, delay_d;
  logic [AW:0]         fill_q, fill_d;
  logic                out_valid_q, out_valid_d;
  logic                dn_valid_q, dn_valid_d;
  logic                dn_sel_q, dn_sel_d;
  logic signed [W-1:0] r_real_q, r_real_d;
  logic signed [W-1:0] r_imag_q, r_imag_d;

  logic [AW:0]         eff;
  logic [AW:0]         fill_base;
  logic [AW-1:0]       rd_addr;
  logic                accept;

  // Real and imaginary parts share one word so a single RAM holds the stream.
  logic [2*W-1:0]      mem [N_MAX];
  logic [2*W-1:0]      ram_rd_q;

  always_comb begin
    if (cfg_delay == '0)
      eff = DELAY_MIN;
    else if (cfg_delay > DELAY_MAX)
      eff = DELAY_MAX;
    else
      eff = cfg_delay;
  end

  // A delay change restarts fill tracking in the same cycle it is seen.
  assign fill_base = (eff != delay_q) ? '0 : fill_q;
  assign accept    = in_valid & ~flush;
  assign rd_addr   = wr_ptr_q - eff[AW-1:0];

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    delay_d     = eff;
    fill_d      = fill_base;
    out_valid_d = 1'b0;
    dn_valid_d  = 1'b0;
    dn_sel_d    = dn_sel_q;
    r_real_d    = r_real_q;
    r_imag_d    = r_imag_q;
    if (flush) begin
      wr_ptr_d = '0;
      fill_d   = '0;
    end else if (accept) begin
      wr_ptr_d    = wr_ptr_q + 1'b1;
      out_valid_d = 1'b1;
      r_real_d    = rx_re_in;
      r_imag_d    = rx_img_in;
      dn_valid_d  = (fill_base >= eff);
      dn_sel_d    = (fill_base >= eff);
      if (fill_base < eff)
        fill_d = fill_base + DELAY_MIN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      delay_q     <= DELAY_MAX;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      dn_valid_q  <= 1'b0;
      dn_sel_q    <= 1'b0;
      r_real_q    <= '0;
      r_imag_q    <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      delay_q     <= delay_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      dn_valid_q  <= dn_valid_d;
      dn_sel_q    <= dn_sel_d;
      r_real_q    <= r_real_d;
      r_imag_q    <= r_imag_d;
    end
  end

  // Read and write in one block: the read sees the old word when D == N_MAX.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr_q] <= {rx_re_in, rx_img_in};
      ram_rd_q      <= mem[rd_addr];
    end
  end

  assign out_valid = out_valid_q;
  assign dN_valid  = dn_valid_q;
  assign r_real    = r_real_q;
  assign r_imag    = r_imag_q;
  assign fill_cnt  = fill_q;
  // The RAM register is not reset, so the flagged select keeps garbage off the outputs.
  assign r_dN_real = dn_sel_q ? ram_rd_q[2*W-1:W] : '0;
  assign r_dN_imag = dn_sel_q ? ram_rd_q[W-1:0]   : '0;

endmodule

// File: tb/tb_delay_n_cfg.sv
// Directed self-checking bench for delay_n_cfg (W=16, N_MAX=256); imaginary input is always -real.
module tb_delay_n_cfg;

  localparam int W     = 16;
  localparam int N_MAX = 256;
  localparam int AW    = $clog2(N_MAX);

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                flush;
  logic [AW:0]         cfg_delay;
  logic signed [W-1:0] rx_re_in;
  logic signed [W-1:0] rx_img_in;
  logic                out_valid;
  logic                dN_valid;
  logic signed [W-1:0] r_real;
  logic signed [W-1:0] r_imag;
  logic signed [W-1:0] r_dN_real;
  logic signed [W-1:0] r_dN_imag;
  logic [AW:0]         fill_cnt;

  int checks = 0;
  int errors = 0;

  delay_n_cfg #(.W(W), .N_MAX(N_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .flush     (flush),
    .cfg_delay (cfg_delay),
    .rx_re_in  (rx_re_in),
    .rx_img_in (rx_img_in),
    .out_valid (out_valid),
    .dN_valid  (dN_valid),
    .r_real    (r_real),
    .r_imag    (r_imag),
    .r_dN_real (r_dN_real),
    .r_dN_imag (r_dN_imag),
    .fill_cnt  (fill_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, sample 1 time unit later.
  task automatic step(input logic v, input logic fl, input int re);
    in_valid  = v;
    flush     = fl;
    rx_re_in  = W'(re);
    rx_img_in = W'(-re);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic ov, input logic dv,
                         input int er, input int edr, input int efill);
    chk({tag, ".out_valid"}, out_valid, ov);
    chk({tag, ".dN_valid"},  dN_valid,  dv);
    chk({tag, ".r_real"},    r_real,    er);
    chk({tag, ".r_imag"},    r_imag,    -er);
    chk({tag, ".r_dN_real"}, r_dN_real, edr);
    chk({tag, ".r_dN_imag"}, r_dN_imag, -edr);
    chk({tag, ".fill_cnt"},  fill_cnt,  efill);
    $display("%-10s ov=%0d dv=%0d re=%0d im=%0d dre=%0d dim=%0d fill=%0d",
             tag, out_valid, dN_valid, r_real, r_imag, r_dN_real, r_dN_imag, fill_cnt);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; cfg_delay = 9'd4;
    rx_re_in = '0; rx_img_in = '0;
    #12;
    chk_all("reset", 1'b0, 1'b0, 0, 0, 0);
    rst = 1'b1;

    // D=4, contiguous stream 1..10
    step(1'b0, 1'b0, 0);
    chk_all("t1_cfg", 1'b0, 1'b0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b0, i);
      chk_all("t1", 1'b1, i >= 5, i, (i >= 5) ? i - 4 : 0, (i < 4) ? i : 4);
    end

    // D=4 with idle gaps: outputs hold, pointer frozen
    step(1'b0, 1'b1, 0);
    chk_all("t2_flush", 1'b0, 1'b0, 10, 6, 0);
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b0, k);
      chk_all("t2_acc", 1'b1, k >= 5, k, (k >= 5) ? k - 4 : 0, (k < 4) ? k : 4);
      step(1'b0, 1'b0, 77);
      chk_all("t2_gap", 1'b0, 1'b0, k, (k >= 5) ? k - 4 : 0, (k < 4) ? k : 4);
    end

    // D=N_MAX: wrap and read-before-write
    cfg_delay = 9'd256;
    step(1'b0, 1'b0, 0);
    chk_all("t3_cfg", 1'b0, 1'b0, 8, 4, 0);
    for (int i = 0; i < 600; i++) begin
      step(1'b1, 1'b0, i);
      chk_all("t3", 1'b1, i >= 256, i, (i >= 256) ? i - 256 : 0, (i < 256) ? i + 1 : 256);
    end

    // cfg 0 -> effective 1 (idle change), then cfg 300 -> 256 (change with in_valid)
    cfg_delay = 9'd0;
    step(1'b0, 1'b0, 0);
    chk_all("t4_cfg0", 1'b0, 1'b0, 599, 343, 0);
    step(1'b1, 1'b0, 1000);
    chk_all("t4_d1a", 1'b1, 1'b0, 1000, 0, 1);
    step(1'b1, 1'b0, 1001);
    chk_all("t4_d1b", 1'b1, 1'b1, 1001, 1000, 1);
    cfg_delay = 9'd300;
    for (int j = 0; j <= 256; j++) begin
      step(1'b1, 1'b0, 2000 + j);
      chk_all("t4_d256", 1'b1, j == 256, 2000 + j, (j == 256) ? 2000 : 0, (j < 256) ? j + 1 : 256);
    end

    // D=8, 20 samples, then flush beats in_valid
    cfg_delay = 9'd8;
    step(1'b0, 1'b0, 0);
    chk_all("t5_cfg", 1'b0, 1'b0, 2256, 2000, 0);
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b0, i);
      chk_all("t5_pre", 1'b1, i >= 9, i, (i >= 9) ? i - 8 : 0, (i < 8) ? i : 8);
    end
    step(1'b1, 1'b1, 99);
    chk_all("t5_flush", 1'b0, 1'b0, 20, 12, 0);
    for (int k = 0; k <= 8; k++) begin
      step(1'b1, 1'b0, 100 + k);
      chk_all("t5_post", 1'b1, k == 8, 100 + k, (k == 8) ? 100 : 0, (k < 8) ? k + 1 : 8);
    end

    // asynchronous reset mid-cycle, then refill from 0
    step(1'b1, 1'b0, 109);
    chk_all("t6_pre", 1'b1, 1'b1, 109, 101, 8);
    #2;
    rst = 1'b0;
    #1;
    chk_all("t6_async", 1'b0, 1'b0, 0, 0, 0);
    #1;
    rst = 1'b1;
    step(1'b0, 1'b0, 0);
    chk_all("t6_cfg", 1'b0, 1'b0, 0, 0, 0);
    for (int k = 0; k <= 8; k++) begin
      step(1'b1, 1'b0, 500 + k);
      chk_all("t6_post", 1'b1, k == 8, 500 + k, (k == 8) ? 500 : 0, (k < 8) ? k + 1 : 8);
    end

    in_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/delay_n_cfg.md
Name: delay_n_cfg

Overview:
- Successor to the fixed-depth delay-N block in the sync/correlation front end.
- Stores I/Q samples in a circular buffer of N_MAX entries, parametrised in width and depth.
- Emits the current sample together with the sample accepted D valid-samples earlier. D is selectable at run time.
- Tracks buffer fill and asserts dN_valid only once D real samples exist, so downstream correlators never consume reset garbage. Supports flush.

Parameters:
- W, 16: signed sample width (real and imaginary each).
- N_MAX, 256: buffer depth and maximum delay. Must be a power of two, ≥4.
- AW, $clog2(N_MAX): pointer width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low.
- in_valid  in  1  input sample strobe.
- flush  in  1  synchronous clear of stream state.
- cfg_delay  in  AW+1  requested delay D, in samples.
- rx_re_in  in  W  signed real input.
- rx_img_in  in  W  signed imaginary input.
- out_valid  out  1  output strobe, one per accepted sample.
- dN_valid  out  1  r_dN_* holds a genuine delayed sample.
- r_real  out  W  registered current real sample.
- r_imag  out  W  registered current imaginary sample.
- r_dN_real  out  W  real sample delayed by D.
- r_dN_imag  out  W  imaginary sample delayed by D.
- fill_cnt  out  AW+1  accepted samples since last clear, saturating at D.

Behaviour:
- Reset (rst=0, asynchronous):
  - out_valid=0, dN_valid=0, all data outputs 0, fill_cnt=0.
  - wr_ptr=0; active delay register delay_q=N_MAX.
  - Buffer contents are not cleared. Garbage is masked by fill tracking.
- Delay clamp: eff = 1 if cfg_delay==0; eff = N_MAX if cfg_delay>N_MAX; otherwise eff = cfg_delay.
- Delay change: any cycle where eff != delay_q:
  - delay_q<=eff, fill_cnt<=0.
  - wr_ptr and buffer contents are unchanged.
- Accept (in_valid=1, no flush):
  - Write the sample at wr_ptr; wr_ptr<=wr_ptr+1, mod N_MAX.
  - Read address = (wr_ptr - delay_q) mod N_MAX. For D=N_MAX it equals wr_ptr, and the read returns the OLD content (read-before-write).
  - Next cycle: out_valid=1, r_real/r_imag = input sample.
  - If fill_cnt (before the increment) ≥ delay_q: dN_valid=1 and r_dN_* = buffer read.
  - Otherwise: dN_valid=0 and r_dN_* = 0.
  - fill_cnt increments, saturating at delay_q.
- Latency: exactly 1 cycle from in_valid to out_valid.
- Throughput: 1 sample/cycle, no backpressure.
- Idle (in_valid=0):
  - out_valid<=0 and dN_valid<=0.
  - Data outputs, pointer and fill_cnt hold.
  - The stream resumes seamlessly; gaps do not count toward D.
- Flush=1:
  - wr_ptr<=0, fill_cnt<=0, out_valid<=0, dN_valid<=0. Data outputs hold.
  - Flush beats in_valid: a sample presented in the same cycle is dropped.
- Delay change together with in_valid:
  - The new delay applies to this sample.
  - The sample is written; fill_cnt becomes 1; dN_valid=0.
- Delay change together with flush: both take effect; the result is empty with delay_q=eff.
- Reset mid-stream: all outputs drop to 0 immediately, without waiting for clk.
- Arithmetic: pointer subtraction is modulo 2^AW. No sign extension; samples pass bit-exact.
- Storage: single-port-style write plus one combinational or registered read is acceptable if the 1-cycle latency holds. Inferable as RAM.

Test Plan:
- Reset, cfg_delay=4, inputs re=1..10, im=-1..-10 on consecutive cycles:
  - out_valid follows each input by 1 cycle.
  - dN_valid first high on the 5th output, with r_dN_real=1, r_dN_imag=-1.
  - 10th output: r_dN=(6,-6); fill_cnt=4.
- cfg_delay=4, in_valid toggling 1,0,1,0 with re=1..8:
  - Outputs hold during gaps.
  - The 5th accepted sample pairs with re=1; pointer does not advance on idle cycles.
- cfg_delay=N_MAX=256, stream re=0..599:
  - Output for sample 256 gives r_dN_real=0 with dN_valid=1.
  - Sample 599 gives 343. Wrap and read-before-write are correct.
- cfg_delay=0, then cfg_delay=300: effective delays 1 and 256. Each change zeroes fill_cnt and drops dN_valid for 1 and 256 samples respectively.
- Stream 20 samples at D=8, then flush together with in_valid (sample re=99):
  - re=99 is not output; fill_cnt=0.
  - The next 8 outputs have dN_valid=0; the 9th pairs with the first post-flush sample.
- Assert rst=0 asynchronously mid-stream between clock edges: all outputs read 0 before the next edge. After release, fill restarts from 0.
